// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 subset control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Controller phases; 6 and 7 are unused encodings.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_ILL    = 3'd5
  } iclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: combinational classification of an RV32 subset instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows instr.
// Ports: instr in; iclass, alu_control, legal, is_bne out.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_e     iclass,
  output logic [3:0]  alu_control,
  output logic        legal,
  output logic        is_bne
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields play no part in control decisions.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    iclass      = CLS_ILL;
    alu_control = ALU_ADD;
    legal       = 1'b0;
    is_bne      = 1'b0;
    case (opcode)
      OP_R: begin
        iclass = CLS_R;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              legal = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              legal       = 1'b1;
              alu_control = ALU_SUB;
            end
          end
          3'b111: begin
            legal       = (funct7 == 7'b0000000);
            alu_control = ALU_AND;
          end
          3'b110: begin
            legal       = (funct7 == 7'b0000000);
            alu_control = ALU_OR;
          end
          default: ;
        endcase
      end
      OP_I: begin
        iclass = CLS_I;
        case (funct3)
          3'b000: legal = 1'b1;
          3'b111: begin
            legal       = 1'b1;
            alu_control = ALU_AND;
          end
          3'b110: begin
            legal       = 1'b1;
            alu_control = ALU_OR;
          end
          default: ;
        endcase
      end
      OP_LOAD: begin
        iclass = CLS_LOAD;
        legal  = (funct3 == 3'b010);
      end
      OP_STORE: begin
        iclass = CLS_STORE;
        legal  = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        iclass      = CLS_BRANCH;
        alu_control = ALU_SUB;
        legal       = (funct3 == 3'b000) || (funct3 == 3'b001);
        is_bne      = (funct3 == 3'b001);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32 subset CPU.
// Latency: branch 3, R/I-ALU and store 4, load 5 cycles plus one per mem_ready=0 cycle.
// Backpressure: holds in FETCH/MEM with constant outputs until mem_ready.
// Ports: clk, rst, instr, alu_zero, mem_ready in; memory, PC, ALU, regfile
//        controls, trap, state and retired out.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src,
  output logic [3:0]          alu_control,
  output logic [1:0]          imm_sel,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                trap,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;

  iclass_e    dec_class;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       dec_bne;
  logic       is_store;
  logic       taken;

  ctrl_decode u_decode (
    .instr       (instr),
    .iclass      (dec_class),
    .alu_control (dec_alu),
    .legal       (dec_legal),
    .is_bne      (dec_bne)
  );

  assign is_store = (dec_class == CLS_STORE);
  assign taken    = dec_bne ? ~alu_zero : alu_zero;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src     = 1'b0;
    alu_control = ALU_AND;
    imm_sel     = IMM_I;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    trap        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_control = dec_alu;
        case (dec_class)
          CLS_R: state_d = S_WB;
          CLS_I: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          CLS_LOAD: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          CLS_STORE: begin
            alu_src = 1'b1;
            imm_sel = IMM_S;
            state_d = S_MEM;
          end
          CLS_BRANCH: begin
            imm_sel  = IMM_B;
            pc_write = taken;
            pc_src   = taken;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req     = 1'b1;
        iord        = 1'b1;
        alu_control = ALU_ADD;
        alu_src     = 1'b1;
        imm_sel     = is_store ? IMM_S : IMM_I;
        mem_we      = is_store;
        if (mem_ready) begin
          state_d = is_store ? S_FETCH : S_WB;
          retire  = is_store;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (dec_class == CLS_LOAD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset kills every enable in the same cycle, aborting any in-flight access.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      alu_src     = 1'b0;
      alu_control = 4'b0000;
      imm_sel     = 2'b00;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      trap        = 1'b0;
    end

    retired_d = retired_q + RETIRE_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign retired = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: randomized scoreboard bench for multicycle_ctrl against a phase-list model.
// Latency: one expected record per clock, compared on the falling edge.
// Backpressure: mem_ready stalls are injected randomly in FETCH and MEM.
module tb_multicycle_ctrl;

  localparam int RW = 4;

  typedef struct packed {
    logic [2:0]    state;
    logic          mem_req;
    logic          mem_we;
    logic          iord;
    logic          ir_write;
    logic          pc_write;
    logic          pc_src;
    logic          alu_src;
    logic [3:0]    alu_control;
    logic [1:0]    imm_sel;
    logic          reg_write;
    logic          mem_to_reg;
    logic          trap;
    logic [RW-1:0] retired;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          alu_zero;
  logic          mem_ready;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src;
  logic [3:0]    alu_control;
  logic [1:0]    imm_sel;
  logic          reg_write, mem_to_reg, trap;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  obs_t  act;
  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    ret      = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_control(alu_control),
    .imm_sel(imm_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
    .state(state), .retired(retired)
  );

  assign act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src,
                alu_control, imm_sel, reg_write, mem_to_reg, trap, retired};

  // Monitor: every cycle that has an expectation queued is compared mid-cycle.
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s @%0t: got %h want %h", t, $time, act, e);
        end
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: name the instruction from the ISA rules.
  function automatic string mnem(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b000) return "add";
    if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'b000) return "sub";
    if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b111) return "and";
    if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b110) return "or";
    if (op == 7'b0010011 && f3 == 3'b000) return "addi";
    if (op == 7'b0010011 && f3 == 3'b111) return "andi";
    if (op == 7'b0010011 && f3 == 3'b110) return "ori";
    if (op == 7'b0000011 && f3 == 3'b010) return "lw";
    if (op == 7'b0100011 && f3 == 3'b010) return "sw";
    if (op == 7'b1100011 && f3 == 3'b000) return "beq";
    if (op == 7'b1100011 && f3 == 3'b001) return "bne";
    return "ill";
  endfunction

  function automatic logic [3:0] alu_of(input string m);
    if (m == "sub" || m == "beq" || m == "bne") return 4'b0110;
    if (m == "and" || m == "andi") return 4'b0000;
    if (m == "or" || m == "ori") return 4'b0001;
    return 4'b0010;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.state   = st;
    e.retired = RW'(ret);
    return e;
  endfunction

  task automatic cycle(input string tag, input obs_t e, input logic rdy, input logic z);
    mem_ready = rdy;
    alu_zero  = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cycle("reset", '0, 1'b1, rb());
    rst = 1'b0;
    ret = 0;
  endtask

  // One instruction as a list of phases; fw/mw are stall cycles in FETCH/MEM.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, input bit abort_mem, input int ntrap);
    string m;
    obs_t  e;
    bit    br, ls, st;
    m  = mnem(ins);
    br = (m == "beq" || m == "bne");
    st = (m == "sw");
    ls = (m == "lw" || st);
    for (int k = 0; k < fw; k++) begin
      e = base(3'd0); e.mem_req = 1'b1;
      cycle("fetch_wait", e, 1'b0, rb());
    end
    e = base(3'd0); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cycle("fetch", e, 1'b1, rb());
    instr = ins;
    cycle("decode", base(3'd1), rb(), rb());
    if (m == "ill") begin
      for (int k = 0; k < ntrap; k++) begin
        e = base(3'd5); e.trap = 1'b1;
        cycle("trap", e, rb(), rb());
      end
      return;
    end
    e = base(3'd2);
    e.alu_control = alu_of(m);
    e.alu_src     = !(m == "add" || m == "sub" || m == "and" || m == "or" || br);
    e.imm_sel     = br ? 2'b10 : (st ? 2'b01 : 2'b00);
    if (br && ((m == "beq") == (z == 1'b1))) begin
      e.pc_write = 1'b1; e.pc_src = 1'b1;
    end
    cycle({"exec_", m}, e, rb(), z);
    if (br) begin
      ret++;
      return;
    end
    if (ls) begin
      e = base(3'd3);
      e.mem_req = 1'b1; e.iord = 1'b1; e.alu_control = 4'b0010; e.alu_src = 1'b1;
      e.imm_sel = st ? 2'b01 : 2'b00; e.mem_we = st;
      for (int k = 0; k < mw; k++) cycle({"mem_wait_", m}, e, 1'b0, rb());
      if (abort_mem) begin
        do_reset();
        return;
      end
      cycle({"mem_", m}, e, 1'b1, rb());
      if (st) begin
        ret++;
        return;
      end
    end
    e = base(3'd4); e.reg_write = 1'b1; e.mem_to_reg = (m == "lw");
    cycle({"wb_", m}, e, rb(), rb());
    ret++;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] im;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    im  = 12'($urandom);
    case ($urandom_range(0, 10))
      0:       return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      1:       return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      2:       return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      3:       return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      4:       return {im, rs1, 3'b000, rd, 7'b0010011};
      5:       return {im, rs1, 3'b111, rd, 7'b0010011};
      6:       return {im, rs1, 3'b110, rd, 7'b0010011};
      7:       return {im, rs1, 3'b010, rd, 7'b0000011};
      8:       return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
      9:       return {im[11:5], rs2, rs1, 3'b000, im[4:0], 7'b1100011};
      default: return {im[11:5], rs2, rs1, 3'b001, im[4:0], 7'b1100011};
    endcase
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [24:0] hi;
    logic [4:0]  rd;
    hi = 25'($urandom);
    rd = 5'($urandom);
    case ($urandom_range(0, 6))
      0:       return {hi, 7'b1101111};
      1:       return {7'b0000000, hi[17:8], 3'b100, rd, 7'b0110011};
      2:       return {7'b0000001, hi[17:8], 3'b000, rd, 7'b0110011};
      3:       return {hi[24:15], 5'b00000, 3'b001, rd, 7'b0010011};
      4:       return {hi[24:12], 3'b000, rd, 7'b0000011};
      5:       return {hi[24:12], 3'b001, rd, 7'b0100011};
      default: return {hi[24:12], 3'b100, rd, 7'b1100011};
    endcase
  endfunction

  initial begin
    int  n;
    bit  ab;
    rst       = 1'b1;
    instr     = '0;
    mem_ready = 1'b1;
    alu_zero  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed sequence from the bring-up checklist.
    run_instr(32'h002081B3, 0, 0, rb(), 1'b0, 0);   // add
    run_instr(32'h0080A283, 0, 2, rb(), 1'b0, 0);   // lw, two MEM stalls
    run_instr(32'h00208463, 1, 0, 1'b1, 1'b0, 0);   // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, 0);   // beq not taken
    run_instr(32'h0020A423, 0, 0, rb(), 1'b0, 0);   // sw
    run_instr(32'h0000007F, 0, 0, rb(), 1'b0, 10);  // illegal opcode
    do_reset();
    run_instr(32'h0020C1B3, 0, 0, rb(), 1'b0, 10);  // xor, unsupported funct3
    do_reset();
    run_instr(32'h0080A283, 0, 1, rb(), 1'b1, 0);   // lw aborted by reset in MEM

    // Random episodes; long runs wrap the narrow retire counter.
    for (int ep = 0; ep < 8; ep++) begin
      n = $urandom_range(10, 24);
      for (int i = 0; i < n; i++) begin
        ab = ($urandom_range(0, 14) == 0);
        run_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), ab, 0);
      end
      if (rb()) run_instr(rand_illegal(), $urandom_range(0, 2), 0, rb(), 1'b0,
                          $urandom_range(3, 10));
      do_reset();
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the single-issue RV32 subset CPU.
- Sequences the shared ALU, register file, PC and the unified memory port across the FETCH / DECODE / EXEC / MEM / WB phases.
- Drives ALU operation select, operand-B source, immediate format and all write enables.
- Waits on a memory ready handshake and traps on unsupported encodings.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction register contents (valid from DECODE onward).
- alu_zero  in  1  ALU zero flag (result == 0).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  load instr register from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- alu_src  out  1  ALU operand B: 0 = rs2 data, 1 = immediate.
- alu_control  out  4  0010 add, 0110 sub, 0000 and, 0001 or.
- imm_sel  out  2  00 I-type, 01 S-type, 10 B-type.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory data.
- trap  out  1  sticky illegal-instruction flag.
- state  out  3  current state, for debug.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Values 6 and 7 are unreachable and must return to FETCH.
- Reset (rst=1 at a clock edge):
  - state <= FETCH, retired <= 0, trap <= 0.
  - All control outputs are forced to 0 combinationally while rst=1.
  - Reset asserted in any state, including mid-MEM, aborts the instruction with no write enables asserted.
- Control outputs are combinational from the state register and instr. All unlisted outputs are 0.
- FETCH:
  - mem_req=1, iord=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: classify instr[6:0]:
  - 0110011 R-type, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch.
  - Any other opcode -> TRAP.
  - Illegal funct3/funct7 also -> TRAP (see legal set below); otherwise go to EXEC.
- Legal set:
  - R: funct3 000 with funct7 0000000 (add) or 0100000 (sub); funct3 111 and 110 with funct7 0000000.
  - I-ALU: funct3 000 / 111 / 110.
  - load/store: funct3 010 only.
  - branch: funct3 000 (beq) and 001 (bne).
- EXEC, alu_control:
  - add/addi and load/store: 0010.
  - sub and branch: 0110.
  - and/andi: 0000.
  - or/ori: 0001.
- EXEC, alu_src and imm_sel:
  - alu_src=1 for I-ALU, load and store; alu_src=0 for R-type and branch.
  - imm_sel: 00 for I-ALU and load, 01 for store, 10 for branch.
- EXEC, next state:
  - R and I-ALU -> WB.
  - load and store -> MEM.
  - branch: taken = (beq & alu_zero) | (bne & ~alu_zero). If taken, pc_write=1 and pc_src=1. Go to FETCH and increment retired.
- MEM:
  - mem_req=1, iord=1, alu_control=0010, alu_src=1, imm_sel as in EXEC. mem_we=1 for store.
  - Holds while mem_ready=0; outputs stay constant during the hold.
  - On mem_ready: load -> WB; store -> FETCH and increment retired.
- WB: reg_write=1, mem_to_reg=1 only for load. Go to FETCH and increment retired.
- TRAP:
  - trap=1, all enables 0.
  - Absorbing: leave only via rst.
  - retired is not incremented for the trapping instruction.
- mem_ready is ignored in DECODE, EXEC, WB and TRAP.
- retired wraps from all-ones to 0 without saturation.
- Instruction latency with zero memory wait:
  - branch 3 cycles.
  - store 4 cycles.
  - R/I-ALU 4 cycles.
  - load 5 cycles.
  - Each cycle of mem_ready=0 in FETCH or MEM adds one cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum;
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALU op constants (ALU_ADD=0010, ALU_SUB=0110, ALU_AND=0000, ALU_OR=0001);
  - imm_sel constants.
- One sub-module, ctrl_decode: combinational classification of instr into class, alu_control, legal flag and branch type. It is reused by the single-cycle control path.
- The FSM, output logic and counter remain in multicycle_ctrl.

Test Plan:
- Reset and idle: hold rst=1 for 3 cycles with mem_ready=1. All outputs must be 0, and state=0 after release. On the first cycle after release: mem_req=1, iord=0.
- add x3,x1,x2 (0x002081B3), mem_ready=1 throughout:
  - states 0,1,2,4,0.
  - EXEC: alu_control=0010, alu_src=0.
  - WB: reg_write=1, mem_to_reg=0.
  - retired=1 after 4 cycles.
- lw x5,8(x1) (0x0080A283), mem_ready low for 2 cycles in MEM:
  - MEM is held 3 cycles with mem_req=1, iord=1, mem_we=0.
  - WB: mem_to_reg=1.
  - Total latency 7 cycles.
- beq with alu_zero=1 (0x00208463):
  - EXEC: alu_control=0110, pc_write=1, pc_src=1, imm_sel=10.
  - Repeat with alu_zero=0: pc_write=0.
  - Back to FETCH and retired increments in both cases.
- sw (0x0020A423), mem_ready=1:
  - MEM: mem_we=1, imm_sel=01.
  - reg_write is never asserted.
  - Returns to FETCH after 4 cycles.
- Illegal opcode 0x0000007F, then xor (funct3 100, R-type):
  - Both enter TRAP: trap=1, state=5, all enables 0, retired unchanged.
  - TRAP persists for 10 cycles and is cleared only by rst.
